// File: rtl/shift_sequencer_if.sv
// Upstream word handshake between a word source and shift_sequencer.
// The source drives valid/data/div; the sequencer answers with ready.
interface shift_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 8
);
   logic             i_valid;
   logic [WIDTH-1:0] i_data;
   logic [DIV_W-1:0] i_div;
   logic             o_ready;

   modport master (output i_valid, output i_data, output i_div, input o_ready);
   modport slave  (input i_valid, input i_data, input i_div, output o_ready);
endinterface

// File: rtl/shift_sequencer.sv
// Sequences an external shift register: one load strobe per accepted word,
// then WIDTH shift strobes spaced div+1 cycles apart, then a done pulse.
module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   shift_sequencer_if.slave up,
   input  logic             i_abort,
   output logic             o_load,
   output logic [WIDTH-1:0] o_ldata,
   output logic             o_shift,
   output logic             o_frame,
   output logic             o_done
);
   localparam int BIT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t           state, state_nx;
   logic [DIV_W-1:0] div_q, div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic             done_q;
   logic             hs, tick, last;

   assign up.o_ready = (state == IDLE);
   assign o_done     = done_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      o_load   = 1'b0;
      o_shift  = 1'b0;
      o_frame  = 1'b0;
      hs       = 1'b0;
      tick     = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            hs = up.i_valid;
            if (hs) state_nx = LOAD;
         end
         LOAD: begin
            o_load   = 1'b1;
            o_frame  = 1'b1;
            state_nx = i_abort ? IDLE : SHIFT;
         end
         SHIFT: begin
            o_frame = 1'b1;
            tick    = (div_cnt == div_q);
            o_shift = tick;
            last    = tick && (bit_cnt == BIT_W'(WIDTH - 1));
            if (i_abort || last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Divider counts 0..div then wraps, so div = all-ones never overflows.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ldata <= '0;
         div_q   <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= last && !i_abort;
         if (hs) begin
            o_ldata <= up.i_data;
            div_q   <= up.i_div;
         end
         case (state)
            LOAD: begin
               div_cnt <= '0;
               bit_cnt <= '0;
            end
            SHIFT: begin
               if (tick) begin
                  div_cnt <= '0;
                  bit_cnt <= bit_cnt + 1'b1;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: expected strobe events are queued
// at handshake time and matched against the DUT outputs every cycle.
module tb_shift_sequencer;
   logic       clk = 1'b0;
   logic       rst, abort;
   logic       load, shift, frame, done;
   logic [7:0] ldata;

   shift_sequencer_if #(.WIDTH(8), .DIV_W(8)) bus ();

   shift_sequencer #(.WIDTH(8), .DIV_W(8)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .up      (bus.slave),
      .i_abort (abort),
      .o_load  (load),
      .o_ldata (ldata),
      .o_shift (shift),
      .o_frame (frame),
      .o_done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int kind; logic [7:0] data;} ev_t;
   typedef struct {logic [7:0] data; logic [7:0] div; int first_off; int done_off;} vec_t;

   ev_t  q[$];
   int   checks = 0, failures = 0;
   int   cyc = 1;
   bit   mon_en = 1'b0;
   int   f_shifts = 0, f_first = 0, f_done = 0, n_done = 0;

   // Cycle number N+1 is the cycle following the N-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         logic [2:0] obs, exp;
         while (q.size() > 0 && q[0].cyc < cyc) begin
            chk($sformatf("missed_kind%0d_at%0d", q[0].kind, q[0].cyc), 0, 1);
            void'(q.pop_front());
         end
         obs = {done === 1'b1, shift === 1'b1, load === 1'b1};
         exp = '0;
         if (q.size() > 0 && q[0].cyc == cyc) exp[q[0].kind] = 1'b1;
         chk("mutex", int'(obs[0]) + int'(obs[1]) + int'(obs[2]) > 1, 0);
         for (int k = 0; k < 3; k++)
            if (obs[k] || exp[k]) chk($sformatf("strobe_kind%0d", k), obs[k], exp[k]);
         if (obs[0] && exp[0]) chk("load_data", ldata, q[0].data);
         if (obs[0]) chk("load_frame", frame, 1);
         if (obs[2]) begin
            chk("done_frame", frame, 0);
            chk("done_ready", bus.o_ready, 1);
         end
         if (obs[0]) begin f_shifts = 0; f_first = 0; end
         if (obs[1]) begin
            if (f_shifts == 0) f_first = cyc;
            f_shifts++;
         end
         if (obs[2]) begin f_done = cyc; n_done++; end
         if (q.size() > 0 && q[0].cyc == cyc) void'(q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_after(input int c);
      while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] dv, output int t);
      bus.i_valid = 1'b1;
      bus.i_data  = d;
      bus.i_div   = dv;
      t = -1;
      for (int i = 0; i < 3000; i++) begin
         if (bus.o_ready === 1'b1 && rst == 1'b0) begin
            t = cyc;
            q.push_back('{t + 1, 0, d});
            for (int k = 1; k <= 8; k++) q.push_back('{t + 1 + k * (int'(dv) + 1), 1, 8'h00});
            q.push_back('{t + 2 + 8 * (int'(dv) + 1), 2, 8'h00});
            step();
            break;
         end
         step();
      end
      if (t < 0) chk("handshake_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && q.size() > 0; i++) step();
      chk("drain_queue", q.size(), 0);
      step();
   endtask

   task automatic wait_cyc(input int c);
      for (int i = 0; i < 5000 && cyc < c; i++) step();
      chk("wait_reach", cyc, c);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[5];
      int   t, t0, t1, t2, c, nd;
      vecs[0] = '{8'hA5, 8'd0, 2, 10};
      vecs[1] = '{8'h3C, 8'd3, 5, 34};
      vecs[2] = '{8'hF0, 8'd1, 3, 18};
      vecs[3] = '{8'h5A, 8'd7, 9, 66};
      vecs[4] = '{8'h81, 8'd2, 4, 26};

      rst = 1'b1; abort = 1'b0;
      bus.i_valid = 1'b0; bus.i_data = '0; bus.i_div = '0;
      step();
      mon_en = 1'b1;
      chk("rst_ready", bus.o_ready, 1);
      chk("rst_load", load, 0);
      chk("rst_shift", shift, 0);
      chk("rst_frame", frame, 0);
      chk("rst_done", done, 0);
      chk("rst_ldata", ldata, 0);
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 5; i++) begin
         send(vecs[i].data, vecs[i].div, t);
         bus.i_valid = 1'b0;
         bus.i_div   = '0;
         bus.i_data  = 8'hFF;
         drain();
         chk($sformatf("v%0d_first_off", i), f_first - t, vecs[i].first_off);
         chk($sformatf("v%0d_done_off", i), f_done - t, vecs[i].done_off);
         chk($sformatf("v%0d_nshift", i), f_shifts, 8);
         chk($sformatf("v%0d_ldata_hold", i), ldata, vecs[i].data);
      end

      // Back-to-back words with i_valid held high throughout.
      send(8'h11, 8'd1, t0);
      send(8'h22, 8'd1, t1);
      send(8'h33, 8'd1, t2);
      bus.i_valid = 1'b0;
      chk("b2b_period01", t1 - t0, 18);
      chk("b2b_period12", t2 - t1, 18);
      drain();
      chk("b2b_ldata", ldata, 8'h33);

      // Abort on the third shift strobe.
      nd = n_done;
      send(8'hC3, 8'd2, t);
      bus.i_valid = 1'b0;
      c = t + 1 + 3 * 3;
      wait_cyc(c);
      abort = 1'b1;
      flush_after(c);
      step();
      abort = 1'b0;
      chk("abort_ready", bus.o_ready, 1);
      chk("abort_frame", frame, 0);
      repeat (20) step();
      chk("abort_nshift", f_shifts, 3);
      chk("abort_nodone", n_done, nd);

      // Abort in IDLE coinciding with a handshake is ignored.
      abort = 1'b1;
      send(8'h6E, 8'd0, t);
      abort = 1'b0;
      bus.i_valid = 1'b0;
      drain();
      chk("idle_abort_nshift", f_shifts, 8);
      chk("idle_abort_ldata", ldata, 8'h6E);

      // Reset after the fifth shift, with a handshake attempted during reset.
      nd = n_done;
      send(8'h9C, 8'd1, t);
      bus.i_valid = 1'b0;
      c = t + 1 + 5 * 2;
      wait_cyc(c);
      rst = 1'b1;
      flush_after(c);
      step();
      chk("mrst_ready", bus.o_ready, 1);
      chk("mrst_load", load, 0);
      chk("mrst_shift", shift, 0);
      chk("mrst_frame", frame, 0);
      chk("mrst_done", done, 0);
      chk("mrst_ldata", ldata, 0);
      bus.i_valid = 1'b1;
      bus.i_data  = 8'h77;
      step();
      chk("mrst_no_hs_load", load, 0);
      rst = 1'b0;
      bus.i_valid = 1'b0;
      step();
      chk("mrst_ldata_after", ldata, 0);
      chk("mrst_nshift", f_shifts, 5);
      chk("mrst_nodone", n_done, nd);
      send(8'h4B, 8'd0, t);
      bus.i_valid = 1'b0;
      drain();
      chk("post_rst_nshift", f_shifts, 8);
      chk("post_rst_done", n_done, nd + 1);

      // Maximum divider.
      send(8'hD2, 8'hFF, t);
      bus.i_valid = 1'b0;
      drain();
      chk("maxdiv_first_off", f_first - t, 257);
      chk("maxdiv_done_off", f_done - t, 2050);
      chk("maxdiv_nshift", f_shifts, 8);

      repeat (5) step();
      chk("sb_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: shift register width; number of shift strobes issued per word.
REQ-002 Parameter DIV_W, default 8: width of the shift-rate divider input.
REQ-003 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset, sampled on the i_clk rising edge.
REQ-005 i_valid  input  1  upstream word available.
REQ-006 i_data  input  WIDTH  upstream parallel word.
REQ-007 i_div  input  DIV_W  shift period minus one, in i_clk cycles.
REQ-008 i_abort  input  1  cancel the frame in progress.
REQ-009 o_ready  output  1  sequencer accepts a word this cycle.
REQ-010 o_load  output  1  one-cycle load strobe to the shift register.
REQ-011 o_ldata  output  WIDTH  word presented to the shift register parallel-load input.
REQ-012 o_shift  output  1  one-cycle shift strobe to the shift register.
REQ-013 o_frame  output  1  high from the load cycle through the last shift cycle.
REQ-014 o_done  output  1  one-cycle pulse on completion of a full frame.

Function
REQ-015 States SHALL be IDLE, LOAD and SHIFT; o_ready = (state == IDLE), driven combinationally from state.
REQ-016 A handshake SHALL occur when i_valid and o_ready are both high at a rising edge; on that edge i_data is captured into o_ldata, i_div is latched internally, and state goes IDLE->LOAD.
REQ-017 i_valid while o_ready is low SHALL be ignored; i_data and i_div changes after the handshake SHALL not affect the current frame.
REQ-018 In LOAD, o_load = 1 and o_frame = 1 for exactly one cycle; state then goes LOAD->SHIFT with the divider counter and the bit counter cleared.
REQ-019 In SHIFT, the divider counter SHALL count 0..div; o_shift SHALL be 1 in each cycle where the count equals div, after which the count wraps to 0.
REQ-020 With handshake at edge T, o_load is high in cycle T+1, and the k-th o_shift (k = 1..WIDTH) is high in cycle T+1+k*(div+1).
REQ-021 div = 0 SHALL produce o_shift in every SHIFT cycle; div = 2^DIV_W-1 SHALL be supported without counter overflow.
REQ-022 After the WIDTH-th o_shift, state goes SHIFT->IDLE; o_done is high and o_frame low in the following cycle, which is also the first o_ready cycle.
REQ-023 A new handshake SHALL be accepted in the o_done cycle; the minimum handshake-to-handshake period is WIDTH*(div+1)+2 cycles.
REQ-024 o_load, o_shift and o_done SHALL be mutually exclusive in every cycle; no two of them are ever high together.
REQ-025 i_abort sampled high in LOAD or SHIFT SHALL return state to IDLE on that edge: no further o_load or o_shift, and no o_done. A strobe already visible in the abort cycle stands.
REQ-026 i_abort in IDLE SHALL be ignored, including when it coincides with a handshake; in that case the handshake proceeds.
REQ-027 o_ldata SHALL hold its value from handshake until the next handshake or reset.
REQ-028 o_frame SHALL be 1 exactly in the LOAD and SHIFT states.

Reset
REQ-029 i_rst high at an edge SHALL force IDLE and clear o_ldata, the divider counter, the bit counter and o_done, regardless of any other input.
REQ-030 While i_rst is high, handshakes SHALL be ignored.
REQ-031 From the first edge with i_rst high, o_load, o_shift, o_frame and o_done read 0 and o_ready reads 1.
REQ-032 Reset mid-frame SHALL abandon the frame with no o_done, and no strobe SHALL be issued after the reset edge.

Verification
REQ-033 WIDTH=8, div=0, i_data=8'hA5 accepted at edge 10 -> o_load in cycle 11 with o_ldata=8'hA5; o_shift in cycles 12-19; o_done and o_ready in cycle 20.
REQ-034 div=3, single word -> 8 o_shift pulses spaced 4 cycles apart, first in cycle T+5, o_done in cycle T+34; i_div changed to 0 mid-frame has no effect.
REQ-035 i_valid held high with div=1 -> handshakes exactly 18 cycles apart; each o_ldata matches the word in order; i_valid during busy is not consumed.
REQ-036 i_abort at the 3rd o_shift cycle -> exactly 3 o_shift pulses, no o_done, o_ready in the next cycle; i_abort in IDLE together with i_valid -> word accepted.
REQ-037 i_rst pulsed during SHIFT after 5 shifts -> no further o_shift, no o_done, o_ldata=0, o_ready=1; the next word runs a full 8-shift frame.
REQ-038 div=8'hFF, single word -> first o_shift at T+257, 8 pulses total, counter wraps correctly; a checker confirms REQ-024 holds over all tests.
